dcache_load_align: RTL and testbench

- MEM-stage load-return path for the data cache; the read-side counterpart of the byte-enable generator used for stores.
- Captures the byte offset and LoadType when a load request is accepted, waits for cache_data_ok, and selects the addressed byte/halfword lane using the same lane mapping as stores. Sign- or zero-extends and holds the 32-bit result until the WB side consumes it.
- Also raises a pipeline stall while a response is outstanding, and swallows responses belonging to flushed loads.

---
 rtl/dcache_load_align_pkg.sv | 15 +
 rtl/dcache_load_align_extend.sv | 37 +++
 rtl/dcache_load_align.sv | 117 +++++++++++
 tb/tb_dcache_load_align.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_load_align_pkg.sv
// Shared CPU definitions for the MEM-stage load path: the LoadType descriptor
// and the size encodings shared by the store byte-enable logic and load alignment.
package CPU_Defines;

    typedef struct packed {
        logic       ReadMem;
        logic       sign;
        logic [1:0] size;
    } LoadType;

    localparam logic [1:0] LOADTYPE_LW = 2'b00;
    localparam logic [1:0] LOADTYPE_LH = 2'b01;
    localparam logic [1:0] LOADTYPE_LB = 2'b10;

endpackage

// File: rtl/dcache_load_align_extend.sv
// Combinational lane select and sign/zero extension for a 32-bit load word.
// Shared with the uncached load path, so it carries no state of its own.
module load_extend
    import CPU_Defines::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [15:0] halfLane;
    logic [7:0]  byteLane;

    // Lane mapping matches the store byte-enables: offset[0] is ignored for halves.
    always_comb begin
        halfLane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (offset)
            2'd0:    byteLane = rdata[7:0];
            2'd1:    byteLane = rdata[15:8];
            2'd2:    byteLane = rdata[23:16];
            default: byteLane = rdata[31:24];
        endcase
    end

    always_comb begin
        result = '0;
        case (size)
            LOADTYPE_LW: result = rdata;
            LOADTYPE_LH: result = {{16{sign & halfLane[15]}}, halfLane};
            LOADTYPE_LB: result = {{24{sign & byteLane[7]}}, byteLane};
            default:     result = '0;
        endcase
    end

endmodule

// File: rtl/dcache_load_align.sv
// MEM-stage load return: tracks one outstanding cached load, aligns and extends
// the returned word, holds it for WB, and discards responses of flushed loads.
module dcache_load_align
    import CPU_Defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] MEM_ALUOut,
    input  LoadType     MEM_LoadType,
    input  logic        req_fire,
    input  logic        flush,
    input  logic        cache_data_ok,
    input  logic [31:0] cache_rdata,
    input  logic        wb_ready,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        load_busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DROP} stateT;

    stateT       state;
    stateT       nextState;
    logic        captureReq;
    logic        captureData;
    logic [1:0]  offsetReg;
    logic [1:0]  sizeReg;
    logic        signReg;
    logic [31:0] extended;
    logic        unusedInputs;

    assign unusedInputs = ^{MEM_ALUOut[31:2], MEM_LoadType.ReadMem};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A flush always wins: a response still pending is routed to DROP so it
    // cannot be mistaken for the next load's data.
    always_comb begin
        nextState   = state;
        captureReq  = 1'b0;
        captureData = 1'b0;
        case (state)
            IDLE: begin
                if (req_fire && flush) begin
                    nextState = DROP;
                end else if (req_fire) begin
                    nextState  = WAIT;
                    captureReq = 1'b1;
                end
            end
            WAIT: begin
                if (cache_data_ok && flush) begin
                    nextState = IDLE;
                end else if (flush) begin
                    nextState = DROP;
                end else if (cache_data_ok) begin
                    nextState   = DONE;
                    captureData = 1'b1;
                end
            end
            DONE: begin
                if (flush) begin
                    nextState = IDLE;
                end else if (wb_ready && req_fire) begin
                    nextState  = WAIT;
                    captureReq = 1'b1;
                end else if (wb_ready) begin
                    nextState = IDLE;
                end
            end
            DROP: begin
                if (cache_data_ok) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offsetReg <= '0;
            sizeReg   <= '0;
            signReg   <= 1'b0;
        end else if (captureReq) begin
            offsetReg <= MEM_ALUOut[1:0];
            sizeReg   <= MEM_LoadType.size;
            signReg   <= MEM_LoadType.sign;
        end
    end

    load_extend extendUnit (
        .rdata  (cache_rdata),
        .offset (offsetReg),
        .size   (sizeReg),
        .sign   (signReg),
        .result (extended)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data <= '0;
        end else if (captureData) begin
            load_data <= extended;
        end
    end

    assign load_valid = (state == DONE);
    assign load_busy  = (state == WAIT) || (state == DROP);

endmodule

// File: tb/tb_dcache_load_align.sv
// Scoreboard bench for dcache_load_align: issued loads push expected results,
// a negedge monitor checks every cycle the DUT presents a valid result.
module tb_dcache_load_align;
    import CPU_Defines::*;

    logic        clk;
    logic        rst;
    logic [31:0] MEM_ALUOut;
    LoadType     MEM_LoadType;
    logic        req_fire;
    logic        flush;
    logic        cache_data_ok;
    logic [31:0] cache_rdata;
    logic        wb_ready;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_busy;

    int          checks;
    int          failures;
    logic [31:0] expectQ[$];

    dcache_load_align dut (
        .clk           (clk),
        .rst           (rst),
        .MEM_ALUOut    (MEM_ALUOut),
        .MEM_LoadType  (MEM_LoadType),
        .req_fire      (req_fire),
        .flush         (flush),
        .cache_data_ok (cache_data_ok),
        .cache_rdata   (cache_rdata),
        .wb_ready      (wb_ready),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_busy     (load_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issue one load, hold the response off for 'gap' WAIT cycles, then return data.
    task automatic applyStimulus(input logic [1:0] addr, input logic sign, input logic [1:0] size,
                                 input logic [31:0] rdata, input int gap, input logic [31:0] expected);
        MEM_ALUOut   = 32'h1000_0000 | {30'h0, addr};
        MEM_LoadType = '{ReadMem: 1'b1, sign: sign, size: size};
        req_fire     = 1'b1;
        expectQ.push_back(expected);
        step();
        req_fire     = 1'b0;
        MEM_ALUOut   = 32'hFFFF_FFFF;
        MEM_LoadType = '{ReadMem: 1'b0, sign: ~sign, size: ~size};
        for (int i = 0; i < gap; i++) begin
            checkOutput("busyWhileWaiting", {31'h0, load_busy}, 32'h1);
            checkOutput("noValidWhileWaiting", {31'h0, load_valid}, 32'h0);
            if (i == gap - 1) begin
                cache_data_ok = 1'b1;
                cache_rdata   = rdata;
            end
            step();
        end
        cache_data_ok = 1'b0;
        cache_rdata   = 32'hA5A5_5A5A;
        checkOutput("validAfterData", {31'h0, load_valid}, 32'h1);
        checkOutput("busyClearInDone", {31'h0, load_busy}, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst && load_valid) begin
            checks++;
            if (expectQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpectedValid: got load_data 0x%08h, expected no result", load_data);
            end else begin
                if (load_data !== expectQ[0]) begin
                    failures++;
                    $display("[TB] FAIL loadData: got 0x%08h, expected 0x%08h", load_data, expectQ[0]);
                end
                if (wb_ready) begin
                    void'(expectQ.pop_front());
                end
            end
        end
        if (!rst && req_fire && load_busy) begin
            failures++;
            $display("[TB] FAIL protocolReqWhileBusy: req_fire=1 with load_busy=1, expected none");
        end
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        MEM_ALUOut    = '0;
        MEM_LoadType  = '0;
        req_fire      = 1'b0;
        flush         = 1'b0;
        cache_data_ok = 1'b0;
        cache_rdata   = '0;
        wb_ready      = 1'b1;
        step();
        step();
        checkOutput("resetValid", {31'h0, load_valid}, 32'h0);
        checkOutput("resetBusy", {31'h0, load_busy}, 32'h0);
        checkOutput("resetData", load_data, 32'h0);
        rst = 1'b0;
        step();
        checkOutput("idleBusy", {31'h0, load_busy}, 32'h0);

        // Signed byte from lane 2, three cycles of stall.
        applyStimulus(2'd2, 1'b1, LOADTYPE_LB, 32'h1280_3456, 3, 32'hFFFF_FF80);
        step();

        // Unsigned upper half, then signed lower half of the same word.
        applyStimulus(2'd2, 1'b0, LOADTYPE_LH, 32'h8001_7FFF, 1, 32'h0000_8001);
        step();
        applyStimulus(2'd0, 1'b1, LOADTYPE_LH, 32'h8001_7FFF, 1, 32'h0000_7FFF);
        step();
        applyStimulus(2'd3, 1'b0, LOADTYPE_LB, 32'hF0E1_D2C3, 2, 32'h0000_00F0);
        step();
        applyStimulus(2'd1, 1'b1, 2'b11, 32'hFFFF_FFFF, 1, 32'h0000_0000);
        step();

        // Result held while WB stalls, then a back-to-back load straight from DONE.
        wb_ready = 1'b0;
        applyStimulus(2'd0, 1'b0, LOADTYPE_LW, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("heldValid", {31'h0, load_valid}, 32'h1);
            checkOutput("heldData", load_data, 32'hDEAD_BEEF);
        end
        step();
        wb_ready = 1'b1;
        applyStimulus(2'd1, 1'b0, LOADTYPE_LB, 32'h1122_3344, 1, 32'h0000_0033);
        step();

        // Flush while waiting: response is dropped.
        MEM_ALUOut   = 32'h2000_0000;
        MEM_LoadType = '{ReadMem: 1'b1, sign: 1'b0, size: LOADTYPE_LW};
        req_fire     = 1'b1;
        step();
        req_fire = 1'b0;
        checkOutput("flushWaitBusy", {31'h0, load_busy}, 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("dropBusy1", {31'h0, load_busy}, 32'h1);
        step();
        checkOutput("dropBusy2", {31'h0, load_busy}, 32'h1);
        cache_data_ok = 1'b1;
        cache_rdata   = 32'h5555_5555;
        step();
        cache_data_ok = 1'b0;
        checkOutput("dropDoneBusy", {31'h0, load_busy}, 32'h0);
        checkOutput("dropDoneValid", {31'h0, load_valid}, 32'h0);
        step();

        // Request and flush together, response swallowed, next load is clean.
        MEM_ALUOut   = 32'h3000_0001;
        MEM_LoadType = '{ReadMem: 1'b1, sign: 1'b1, size: LOADTYPE_LB};
        req_fire     = 1'b1;
        flush        = 1'b1;
        step();
        req_fire = 1'b0;
        flush    = 1'b0;
        checkOutput("reqFlushBusy", {31'h0, load_busy}, 32'h1);
        cache_data_ok = 1'b1;
        cache_rdata   = 32'h0000_8000;
        step();
        cache_data_ok = 1'b0;
        checkOutput("swallowBusy", {31'h0, load_busy}, 32'h0);
        checkOutput("swallowValid", {31'h0, load_valid}, 32'h0);
        applyStimulus(2'd3, 1'b1, LOADTYPE_LB, 32'hA500_0000, 2, 32'hFFFF_FFA5);
        step();

        // Asynchronous reset in the middle of a wait.
        MEM_ALUOut   = 32'h4000_0000;
        MEM_LoadType = '{ReadMem: 1'b1, sign: 1'b0, size: LOADTYPE_LW};
        req_fire     = 1'b1;
        step();
        req_fire = 1'b0;
        checkOutput("preResetBusy", {31'h0, load_busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncResetBusy", {31'h0, load_busy}, 32'h0);
        checkOutput("asyncResetValid", {31'h0, load_valid}, 32'h0);
        checkOutput("asyncResetData", load_data, 32'h0);
        step();
        rst           = 1'b0;
        cache_data_ok = 1'b1;
        cache_rdata   = 32'h7777_7777;
        step();
        cache_data_ok = 1'b0;
        checkOutput("lateDataValid", {31'h0, load_valid}, 32'h0);
        checkOutput("lateDataBusy", {31'h0, load_busy}, 32'h0);
        step();
        checkOutput("lateDataValid2", {31'h0, load_valid}, 32'h0);

        checkOutput("scoreboardDrained", expectQ.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
